// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester ports and single-port memory bus of mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [31:0]   dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          stall_if;
    logic          stall_dm;

    // Arbiter side: serves the two requesters and drives the memory.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
    );

    // Environment side: fetch unit, data stage and memory model.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto a single-port memory; ARB_ROUND_ROBIN_EN selects round-robin over fixed data priority
module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

    state_t        state;
    logic [2:0]    cnt;
    logic          own_dm;
    logic          we_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic          done_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   dm_rdata_q;
    logic          pick_dm;
    logic          any_req;
    logic          grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic          last_dm;

    // On a tie the port that was not served last wins.
    always_comb begin
        pick_dm = bus.dm_req & (~bus.if_req | ~last_dm);
    end
`else
    // Data stage always beats instruction fetch.
    always_comb begin
        pick_dm = bus.dm_req;
    end
`endif

    assign any_req = bus.if_req | bus.dm_req;
    assign grant   = (state == IDLE) & any_req & ~rst;

    assign bus.if_gnt = grant & ~pick_dm;
    assign bus.dm_gnt = grant & pick_dm;

    // Single transaction FSM; done_q is pre-decoded one cycle early so the
    // completion strobe comes straight from a flop in the cycle counter==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            own_dm     <= 1'b0;
            we_q       <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm    <= 1'b1;
`endif
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;

            if (done_q) begin
                if (!own_dm) begin
                    if_rdata_q <= bus.mem_rdata;
                end else if (!we_q) begin
                    dm_rdata_q <= bus.mem_rdata;
                end
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        own_dm   <= pick_dm;
                        mem_en_q <= 1'b1;
                        mem_we_q <= pick_dm & bus.dm_we;
                        if (pick_dm) begin
                            addr_q  <= bus.dm_addr;
                            we_q    <= bus.dm_we;
                            wdata_q <= bus.dm_wdata;
                        end else begin
                            addr_q  <= bus.if_addr;
                            we_q    <= 1'b0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_dm  <= pick_dm;
`endif
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt    <= LAT_M1;
                    done_q <= (LAT_M1 == 3'd0);
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt    <= cnt - 3'd1;
                        done_q <= (cnt == 3'd1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_rvalid = done_q & ~own_dm;
    assign bus.dm_rvalid = done_q & own_dm;

    // Read data is forwarded from memory in the completion cycle, held otherwise.
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_rdata  = (bus.dm_rvalid & ~we_q) ? bus.mem_rdata : dm_rdata_q;

    assign bus.stall_if  = bus.if_req & ~bus.if_rvalid;
    assign bus.stall_dm  = bus.dm_req & ~bus.dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32)) b0 ();
    mem_port_arbiter_if #(.AW(32)) b1 ();
    mem_port_arbiter_if #(.AW(32)) b7 ();

    mem_port_arbiter #(.LATENCY(2), .AW(32)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    mem_port_arbiter #(.LATENCY(1), .AW(32)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_port_arbiter #(.LATENCY(7), .AW(32)) u7 (.clk(clk), .rst(rst), .bus(b7.slave));

    localparam int L0 = 2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        ifr;
        logic        dmr;
        logic        we;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        e_ifg;
        logic        e_dmg;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b0.if_req = 1'b0; b0.if_addr = '0; b0.dm_req = 1'b0; b0.dm_we = 1'b0;
        b0.dm_addr = '0; b0.dm_wdata = '0; b0.mem_rdata = '0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
        b1.dm_addr = '0; b1.dm_wdata = '0; b1.mem_rdata = '0;
        b7.if_req = 1'b0; b7.if_addr = '0; b7.dm_req = 1'b0; b7.dm_we = 1'b0;
        b7.dm_addr = '0; b7.dm_wdata = '0; b7.mem_rdata = '0;
    endtask

    initial begin
        logic [31:0] if_hold;
        logic [31:0] dm_hold;
        logic [31:0] exp_d;
        int en1, en7, rv1, rv7, cnt1, cnt7;

        idle_inputs();
        rst = 1'b1;
        b0.if_req = 1'b1;
        b0.dm_req = 1'b1;
        b0.if_addr = 32'h1234;
        b0.dm_addr = 32'h5678;
        nxt();
        nxt();

        // Reset state, grants forced low while rst is high
        @(negedge clk);
        chk1("rst_if_gnt", b0.if_gnt, 1'b0);
        chk1("rst_dm_gnt", b0.dm_gnt, 1'b0);
        chk1("rst_mem_en", b0.mem_en, 1'b0);
        chk1("rst_mem_we", b0.mem_we, 1'b0);
        chk1("rst_if_rvalid", b0.if_rvalid, 1'b0);
        chk1("rst_dm_rvalid", b0.dm_rvalid, 1'b0);
        chk("rst_mem_addr", b0.mem_addr, 32'h0);
        chk("rst_mem_wdata", b0.mem_wdata, 32'h0);
        chk("rst_if_rdata", b0.if_rdata, 32'h0);
        chk("rst_dm_rdata", b0.dm_rdata, 32'h0);
        nxt();
        idle_inputs();
        rst = 1'b0;
        nxt();

        // Table-driven single transactions from IDLE
        tv[0] = '{1'b1, 1'b0, 1'b0, 32'h64, 32'h0,  32'h0,        32'h00221820, 1'b1, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 32'h68, 32'h8,  32'h0,        32'h11112222, 1'b0, 1'b1};
        tv[2] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h10, 32'hDEADBEEF, 32'h33334444, 1'b0, 1'b1};
`ifdef ARB_ROUND_ROBIN_EN
        tv[3] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 32'h0,        32'h55556666, 1'b1, 1'b0};
`else
        tv[3] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 32'h0,        32'h55556666, 1'b0, 1'b1};
`endif
        tv[4] = '{1'b0, 1'b0, 1'b0, 32'h44, 32'h24, 32'h0,        32'h77778888, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'hFC, 32'h0,        32'h9999AAAA, 1'b0, 1'b1};

        if_hold = 32'h0;
        dm_hold = 32'h0;
        for (int i = 0; i < 6; i++) begin
            b0.if_req = tv[i].ifr;   b0.if_addr = tv[i].ia;
            b0.dm_req = tv[i].dmr;   b0.dm_we = tv[i].we;
            b0.dm_addr = tv[i].da;   b0.dm_wdata = tv[i].wd;
            b0.mem_rdata = 32'hBAD0BAD0;
            @(negedge clk);
            chk1($sformatf("v%0d_if_gnt", i), b0.if_gnt, tv[i].e_ifg);
            chk1($sformatf("v%0d_dm_gnt", i), b0.dm_gnt, tv[i].e_dmg);
            nxt();
            b0.if_req = 1'b0;
            b0.dm_req = 1'b0;
            @(negedge clk);
            chk1($sformatf("v%0d_mem_en", i), b0.mem_en, tv[i].e_ifg | tv[i].e_dmg);
            chk1($sformatf("v%0d_mem_we", i), b0.mem_we, tv[i].e_dmg & tv[i].we);
            if (tv[i].e_ifg | tv[i].e_dmg)
                chk($sformatf("v%0d_mem_addr", i), b0.mem_addr, tv[i].e_dmg ? tv[i].da : tv[i].ia);
            if (tv[i].e_dmg & tv[i].we)
                chk($sformatf("v%0d_mem_wdata", i), b0.mem_wdata, tv[i].wd);
            nxt();
            @(negedge clk);
            chk1($sformatf("v%0d_early_rvalid", i), b0.if_rvalid | b0.dm_rvalid, 1'b0);
            nxt();
            b0.mem_rdata = tv[i].rd;
            @(negedge clk);
            chk1($sformatf("v%0d_if_rvalid", i), b0.if_rvalid, tv[i].e_ifg);
            chk1($sformatf("v%0d_dm_rvalid", i), b0.dm_rvalid, tv[i].e_dmg);
            if (tv[i].e_ifg) if_hold = tv[i].rd;
            if (tv[i].e_dmg && !tv[i].we) dm_hold = tv[i].rd;
            chk($sformatf("v%0d_if_rdata", i), b0.if_rdata, if_hold);
            chk($sformatf("v%0d_dm_rdata", i), b0.dm_rdata, dm_hold);
            nxt();
            b0.mem_rdata = 32'h0;
        end

`ifdef ARB_ROUND_ROBIN_EN
        // Both requests held from reset release: IF, DM, IF, DM every 4 cycles
        rst = 1'b1;
        b0.if_req = 1'b1;
        b0.dm_req = 1'b1;
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk1($sformatf("rr_if_gnt_k%0d", k), b0.if_gnt, (k % 8) == 0);
            chk1($sformatf("rr_dm_gnt_k%0d", k), b0.dm_gnt, (k % 8) == 4);
            nxt();
        end
        b0.if_req = 1'b0;
        b0.dm_req = 1'b0;
        repeat (4) nxt();
`else
        // Fixed priority: data wins, fetch waits and stalls until its own rvalid
        b0.if_req = 1'b1; b0.if_addr = 32'h100;
        b0.dm_req = 1'b1; b0.dm_we = 1'b0; b0.dm_addr = 32'h8;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk1($sformatf("pri_dm_gnt_k%0d", k), b0.dm_gnt, k == 0);
            chk1($sformatf("pri_if_gnt_k%0d", k), b0.if_gnt, k == 4);
            chk1($sformatf("pri_stall_if_k%0d", k), b0.stall_if, k < 7);
            nxt();
            if (k == 0) b0.dm_req = 1'b0;
        end
        b0.if_req = 1'b0;
        nxt();
`endif

        // Reset during WAIT aborts the fetch; held request is granted right after
        b0.if_req = 1'b1; b0.if_addr = 32'h200;
        @(negedge clk);
        chk1("abort_first_gnt", b0.if_gnt, 1'b1);
        nxt();
        @(negedge clk);
        chk1("abort_mem_en", b0.mem_en, 1'b1);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk1("abort_gnt_in_rst", b0.if_gnt, 1'b0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk1("abort_no_rvalid", b0.if_rvalid, 1'b0);
        chk1("abort_mem_en_low", b0.mem_en, 1'b0);
        chk1("abort_regrant", b0.if_gnt, 1'b1);
        nxt();
        b0.if_req = 1'b0;
        repeat (4) nxt();

        // LATENCY=1 and LATENCY=7 single reads
        b1.if_req = 1'b1; b1.if_addr = 32'h300; b1.mem_rdata = 32'hA5A50001;
        b7.if_req = 1'b1; b7.if_addr = 32'h304; b7.mem_rdata = 32'hA5A50007;
        en1 = -100; en7 = -100; rv1 = -100; rv7 = -100; cnt1 = 0; cnt7 = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk1("lat1_gnt", b1.if_gnt, 1'b1);
                chk1("lat7_gnt", b7.if_gnt, 1'b1);
            end
            if (b1.mem_en) en1 = k;
            if (b7.mem_en) en7 = k;
            if (b1.if_rvalid) begin
                rv1 = k; cnt1++;
                chk("lat1_rdata", b1.if_rdata, 32'hA5A50001);
            end
            if (b7.if_rvalid) begin
                rv7 = k; cnt7++;
                chk("lat7_rdata", b7.if_rdata, 32'hA5A50007);
            end
            nxt();
            b1.if_req = 1'b0;
            b7.if_req = 1'b0;
        end
        chk("lat1_delay", 32'(rv1 - en1), 32'd1);
        chk("lat7_delay", 32'(rv7 - en7), 32'd7);
        chk("lat1_pulses", 32'(cnt1), 32'd1);
        chk("lat7_pulses", 32'(cnt7), 32'd1);

        // Randomized traffic against a cycle-schedule reference model
        rst = 1'b1;
        idle_inputs();
        nxt();
        rst = 1'b0;
        begin
            int free_at, en_at, cmp_at;
            logic p_dm, p_we, last_dm, w_dm, done;
            logic [31:0] p_addr, p_wd, e_if, e_dm;
            logic ifr, dmr;
            free_at = 0; en_at = -1; cmp_at = -1;
            p_dm = 1'b0; p_we = 1'b0; last_dm = 1'b1;
            p_addr = 32'h0; p_wd = 32'h0;
            if_hold = 32'h0; dm_hold = 32'h0;
            for (int t = 0; t < 400; t++) begin
                ifr = ($urandom_range(0, 2) != 0);
                dmr = ($urandom_range(0, 2) != 0);
                b0.if_req = ifr;          b0.dm_req = dmr;
                b0.if_addr = $urandom;    b0.dm_addr = $urandom;
                b0.dm_we = $urandom_range(0, 1) == 1;
                b0.dm_wdata = $urandom;   b0.mem_rdata = $urandom;
                w_dm = 1'b0;
                if (t >= free_at && (ifr || dmr)) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w_dm = dmr && (!ifr || !last_dm);
`else
                    w_dm = dmr;
`endif
                    p_dm = w_dm;
                    p_we = w_dm && b0.dm_we;
                    p_addr = w_dm ? b0.dm_addr : b0.if_addr;
                    if (w_dm) p_wd = b0.dm_wdata;
                    en_at = t + 1;
                    cmp_at = t + L0 + 1;
                    free_at = t + L0 + 2;
                    last_dm = w_dm;
                    @(negedge clk);
                    chk1("rnd_if_gnt", b0.if_gnt, !w_dm);
                    chk1("rnd_dm_gnt", b0.dm_gnt, w_dm);
                end else begin
                    @(negedge clk);
                    chk1("rnd_no_gnt", b0.if_gnt | b0.dm_gnt, 1'b0);
                end
                chk1("rnd_mem_en", b0.mem_en, t == en_at);
                chk1("rnd_mem_we", b0.mem_we, (t == en_at) && p_we);
                if (t == en_at) chk("rnd_mem_addr", b0.mem_addr, p_addr);
                if (t == en_at && p_we) chk("rnd_mem_wdata", b0.mem_wdata, p_wd);
                done = (t == cmp_at);
                chk1("rnd_if_rvalid", b0.if_rvalid, done && !p_dm);
                chk1("rnd_dm_rvalid", b0.dm_rvalid, done && p_dm);
                e_if = (done && !p_dm) ? b0.mem_rdata : if_hold;
                e_dm = (done && p_dm && !p_we) ? b0.mem_rdata : dm_hold;
                chk("rnd_if_rdata", b0.if_rdata, e_if);
                chk("rnd_dm_rdata", b0.dm_rdata, e_dm);
                if_hold = e_if;
                dm_hold = e_dm;
                chk1("rnd_stall_if", b0.stall_if, ifr && !(done && !p_dm));
                chk1("rnd_stall_dm", b0.stall_dm, dmr && !(done && p_dm));
                nxt();
            end
        end

        idle_inputs();
        nxt();
        exp_d = 32'h0;
        if (exp_d != 32'h0) n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, cycles from mem_en to valid mem_rdata; legal range 1..7.
REQ-002 Parameter AW, default 32, address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request, read only.
REQ-006 if_addr  input  AW  fetch address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch complete; if_rdata valid.
REQ-009 if_rdata  output  32  fetch read data.
REQ-010 dm_req  input  1  data-stage request.
REQ-011 dm_we  input  1  data request is a write.
REQ-012 dm_addr  input  AW  data address.
REQ-013 dm_wdata  input  32  write data.
REQ-014 dm_gnt  output  1  data request accepted this cycle.
REQ-015 dm_rvalid  output  1  data access complete (read or write); dm_rdata valid for reads.
REQ-016 dm_rdata  output  32  data read data.
REQ-017 mem_en  output  1  single-port memory access strobe.
REQ-018 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-019 mem_addr  output  AW  memory address.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  memory read data, valid LATENCY cycles after mem_en.
REQ-022 stall_if  output  1  = if_req & ~if_rvalid.
REQ-023 stall_dm  output  1  = dm_req & ~dm_rvalid.

Function
REQ-024 FSM states IDLE, ISSUE, WAIT; at most one transaction outstanding.
REQ-025 IDLE: if any req is high, exactly one gnt is asserted combinationally that cycle; winner's addr/we/wdata and port id are registered; next state ISSUE. No req: stay IDLE, both gnt low.
REQ-026 Grants are issued only in IDLE; gnt is low in ISSUE and WAIT.
REQ-027 ISSUE (cycle E): mem_en=1, mem_we/mem_addr/mem_wdata from registered values; load counter with LATENCY-1; next state WAIT.
REQ-028 mem_en, mem_we are low in every state other than ISSUE; mem_addr/mem_wdata hold last registered values.
REQ-029 WAIT: counter decrements each cycle; when counter==0 (cycle E+LATENCY) the owning port's rvalid pulses one cycle and its rdata = mem_rdata that cycle; next state IDLE.
REQ-030 Non-owning port's rvalid stays low; non-owning rdata holds its last value.
REQ-031 Writes pulse dm_rvalid at E+LATENCY like reads; dm_rdata is unchanged on write completion.
REQ-032 Req deasserted after gnt does not cancel the transaction; rvalid still pulses.
REQ-033 Request-to-completion latency is LATENCY+1 cycles after the grant cycle; minimum spacing between grants LATENCY+2 cycles.
REQ-034 A req held high through its own rvalid cycle is re-arbitrated in the following IDLE cycle as a new request.
REQ-035 Counter width 3 bits; no wrap-around beyond LATENCY-1.

Reset
REQ-036 While rst is high at a clock edge: state IDLE, counter 0, all gnt/rvalid low, mem_en/mem_we low, mem_addr/mem_wdata/if_rdata/dm_rdata 0, round-robin pointer = DM (last served).
REQ-037 Reset in ISSUE or WAIT aborts the transaction: no rvalid is ever produced for it.
REQ-038 gnt outputs are forced low while rst is high, regardless of req.

Configuration
REQ-039 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE grant the port not served last; pointer updates on each gnt.
REQ-040 Without ARB_ROUND_ROBIN_EN: dm_req has fixed priority over if_req; no pointer register exists.

Verification
REQ-041 LATENCY=2, if_req=1 if_addr=0x64 alone, mem_rdata=0x00221820 at E+2 -> if_gnt at T, mem_en at T+1, if_rvalid with if_rdata=0x00221820 at T+3.
REQ-042 Fixed priority, if_req and dm_req both high at T, dm_we=0 dm_addr=0x8 -> dm_gnt at T, if_gnt at T+4; stall_if high T..T+6, low T+7.
REQ-043 ARB_ROUND_ROBIN_EN, both req held high continuously from reset release -> grants alternate IF, DM, IF, DM every 4 cycles.
REQ-044 dm_we=1 dm_addr=0x10 dm_wdata=0xDEADBEEF -> mem_en=mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF for one cycle; dm_rvalid two cycles later; dm_rdata unchanged.
REQ-045 rst asserted in WAIT after if grant -> no if_rvalid, mem_en low, state IDLE; if_req still high gets if_gnt first cycle after rst falls.
REQ-046 LATENCY=1 and LATENCY=7, single read -> rvalid exactly 1 and 7 cycles after mem_en respectively.
